mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access / write-back stage of the processor pipeline: the block directly upstream of the general-purpose register file. It takes the executed instruction from the EX stage, performs any load or store on the system bus with a req/ready handshake, and drives the register file write port (`GprWE_`, `GprWrAddr`, `GprWrData`) from registered outputs. While a bus access is in flight it stalls the upstream pipeline.

## Interface
Parameters:
- `WORD_W`, 32: data and address width.
- `REG_ADDR_W`, 5: register address width.
- `TIMEOUT_CYC`, 255: maximum wait cycles for `BusRdy_` before an access is aborted. Range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_`  in  1  one clock; reset is synchronous and active-high (`reset_`=1 resets on the next rising edge).
- `Stall`  in  1  global hold from pipeline control.
- `Flush`  in  1  replaces the incoming instruction with a bubble.
- `ExEn`  in  1  EX output holds a valid instruction.
- `ExMemOp`  in  2  memory operation: 00 none, 01 load, 10 store, 11 reserved (treated as none).
- `ExOut`  in  WORD_W  ALU result: the memory byte address for loads and stores, otherwise the write-back value.
- `ExMemWrData`  in  WORD_W  store data.
- `ExDstAddr`  in  REG_ADDR_W  destination register.
- `ExGprWE_`  in  1  active-low destination write enable.
- `BusReq`  out  1  bus request.
- `BusRw`  out  1  1 = read, 0 = write.
- `BusAddr`  out  WORD_W-2  word address, equal to `ExOut[WORD_W-1:2]` as latched.
- `BusWrData`  out  WORD_W  store data.
- `BusRdy_`  in  1  active-low transfer complete.
- `BusRdData`  in  WORD_W  load data, valid when `BusRdy_`=0.
- `BusyStall`  out  1  upstream must hold EX outputs.
- `MissAlign`  out  1  one-cycle pulse on a misaligned load or store.
- `BusErr`  out  1  one-cycle pulse on an access timeout.
- `GprWE_`  out  1  active-low register file write enable.
- `GprWrAddr`  out  REG_ADDR_W  register file write address.
- `GprWrData`  out  WORD_W  register file write data.

## Operation
- FSM states:
  - IDLE: accept instructions from EX.
  - ACCESS: bus transfer in flight. `BusyStall`=1 and EX inputs are ignored.
- IDLE, `Stall`=1: all output registers hold their current values. Repeating a write of the same value is harmless.
- IDLE, `Flush`=1 (and `Stall`=0): capture a bubble: `GprWE_`=1, `MissAlign`=0, `BusErr`=0.
- IDLE, `ExEn`=0: capture a bubble.
- IDLE, valid instruction, `ExMemOp` none or 11: `GprWE_`=`ExGprWE_`, `GprWrAddr`=`ExDstAddr`, `GprWrData`=`ExOut`.
- IDLE, valid load or store with `ExOut[1:0]`≠0:
  - No bus access.
  - `MissAlign`=1 for one cycle and `GprWE_`=1.
  - State stays IDLE.
- IDLE, valid aligned load or store:
  - Latch address, store data, `ExDstAddr` and `ExGprWE_`.
  - Set `BusReq`=1 and `BusRw` (1 for load, 0 for store).
  - Clear the timeout counter, set `GprWE_`=1, go to ACCESS.
- ACCESS, `BusRdy_` sampled 0:
  - Load: `GprWE_`=latched `ExGprWE_`, `GprWrData`=`BusRdData`, `GprWrAddr`=latched destination.
  - Store: `GprWE_`=1.
  - `BusReq`=0, go to IDLE.
- ACCESS, `BusRdy_`=1: the counter increments. On reaching `TIMEOUT_CYC` (counter width 8, saturating): `BusReq`=0, `BusErr`=1 for one cycle, `GprWE_`=1, go to IDLE.
- ACCESS: `Flush` and `Stall` are ignored. Bus transfers are not abortable.
- `BusyStall` = (state == ACCESS), registered.
- Reset values: state IDLE, `BusReq` 0, `BusRw` 1, `BusAddr` 0, `BusWrData` 0, `BusyStall` 0, `MissAlign` 0, `BusErr` 0, `GprWE_` 1, `GprWrAddr` 0, `GprWrData` 0, counter 0.
- Reset during ACCESS: `BusReq` drops on the reset edge and no GPR write occurs.

## Timing
- Non-memory instruction: presented at EX in cycle n → write port valid in cycle n+1 (one-cycle latency).
- Aligned access:
  - Captured at edge n.
  - `BusReq` and `BusyStall` are high from cycle n+1.
  - `BusRdy_` low in cycle n+k → write port valid and `BusyStall` low in cycle n+k+1.
  - The next EX instruction is consumed at the end of cycle n+k+1.
- Zero-wait bus (`BusRdy_` low in n+1): load result appears in n+2, giving a 2-cycle load latency and one stall cycle.
- `BusRdy_` and `BusRdData` are sampled only in ACCESS. In IDLE they are don't-care.
- `MissAlign` and `BusErr` are high for exactly one cycle and never both in the same cycle.

## Test plan
- Reset, then ADD-type instruction (`ExMemOp`=00, `ExOut`=0x1234, `ExDstAddr`=3, `ExGprWE_`=0) → next cycle `GprWE_`=0, `GprWrAddr`=3, `GprWrData`=0x1234.
- Load from 0x100 with `BusRdy_` low after 3 cycles, `BusRdData`=0xDEADBEEF, destination 7 → `BusAddr`=0x40, `BusRw`=1, `BusyStall` high 3 cycles, then write of 0xDEADBEEF to r7 once.
- Store to 0x8 with data 0xA5A5A5A5, zero-wait bus → one `BusReq` cycle with `BusRw`=0 and `BusWrData`=0xA5A5A5A5; `GprWE_` stays 1 throughout.
- Load from 0x102 → `MissAlign` pulses once, `BusReq` stays 0, no GPR write.
- Load with `BusRdy_` held high and `TIMEOUT_CYC`=4 → `BusErr` pulse after 4 ACCESS cycles, `BusReq` drops, no write. Then `Flush`=1 with a valid instruction → bubble.
- Assert `reset_` during ACCESS → next cycle all outputs at their reset values; a subsequent `BusRdy_`=0 has no effect.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: performs loads and stores on the system bus
// and drives the register file write port from registered outputs.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | accepting instructions from EX
// S_ACCESS | bus transfer in flight, EX held off via BusyStall
module mem_wb_stage #(
  parameter int WORD_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  ExEn,
  input  logic [1:0]            ExMemOp,
  input  logic [WORD_W-1:0]     ExOut,
  input  logic [WORD_W-1:0]     ExMemWrData,
  input  logic [REG_ADDR_W-1:0] ExDstAddr,
  input  logic                  ExGprWE_,
  output logic                  BusReq,
  output logic                  BusRw,
  output logic [WORD_W-3:0]     BusAddr,
  output logic [WORD_W-1:0]     BusWrData,
  input  logic                  BusRdy_,
  input  logic [WORD_W-1:0]     BusRdData,
  output logic                  BusyStall,
  output logic                  MissAlign,
  output logic                  BusErr,
  output logic                  GprWE_,
  output logic [REG_ADDR_W-1:0] GprWrAddr,
  output logic [WORD_W-1:0]     GprWrData
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYC);

  state_t                  r_state, w_state_nxt;
  logic                    r_bus_req, w_bus_req;
  logic                    r_bus_rw, w_bus_rw;
  logic [WORD_W-3:0]       r_bus_addr, w_bus_addr;
  logic [WORD_W-1:0]       r_bus_wdata, w_bus_wdata;
  logic                    r_busy;
  logic                    r_miss, w_miss;
  logic                    r_err, w_err;
  logic                    r_gpr_we_n, w_gpr_we_n;
  logic [REG_ADDR_W-1:0]   r_gpr_addr, w_gpr_addr;
  logic [WORD_W-1:0]       r_gpr_data, w_gpr_data;
  logic [REG_ADDR_W-1:0]   r_dst, w_dst;
  logic                    r_dst_we_n, w_dst_we_n;
  logic [7:0]              r_cnt, w_cnt;

  logic                    w_valid, w_is_mem, w_is_load, w_misal, w_timeout;
  logic [7:0]              w_cnt_inc;

  assign w_valid   = ExEn & ~Flush;
  assign w_is_load = (ExMemOp == 2'b01);
  assign w_is_mem  = (ExMemOp == 2'b01) | (ExMemOp == 2'b10);
  assign w_misal   = |ExOut[1:0];
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_timeout = (w_cnt_inc == TO_CNT);

  always_ff @(posedge clk) begin
    if (reset_) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_rw    <= 1'b1;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_busy      <= 1'b0;
      r_miss      <= 1'b0;
      r_err       <= 1'b0;
      r_gpr_we_n  <= 1'b1;
      r_gpr_addr  <= '0;
      r_gpr_data  <= '0;
      r_dst       <= '0;
      r_dst_we_n  <= 1'b1;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_req   <= w_bus_req;
      r_bus_rw    <= w_bus_rw;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
      r_busy      <= (w_state_nxt == S_ACCESS);
      r_miss      <= w_miss;
      r_err       <= w_err;
      r_gpr_we_n  <= w_gpr_we_n;
      r_gpr_addr  <= w_gpr_addr;
      r_gpr_data  <= w_gpr_data;
      r_dst       <= w_dst;
      r_dst_we_n  <= w_dst_we_n;
      r_cnt       <= w_cnt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!Stall && w_valid && w_is_mem && !w_misal) w_state_nxt = S_ACCESS;
      S_ACCESS: if (!BusRdy_ || w_timeout) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Pulses clear whenever not re-asserted, so a stall never stretches them.
  always_comb begin
    w_bus_req   = r_bus_req;
    w_bus_rw    = r_bus_rw;
    w_bus_addr  = r_bus_addr;
    w_bus_wdata = r_bus_wdata;
    w_miss      = 1'b0;
    w_err       = 1'b0;
    w_gpr_we_n  = r_gpr_we_n;
    w_gpr_addr  = r_gpr_addr;
    w_gpr_data  = r_gpr_data;
    w_dst       = r_dst;
    w_dst_we_n  = r_dst_we_n;
    w_cnt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (!Stall) begin
          if (!w_valid) begin
            w_gpr_we_n = 1'b1;
          end else if (!w_is_mem) begin
            w_gpr_we_n = ExGprWE_;
            w_gpr_addr = ExDstAddr;
            w_gpr_data = ExOut;
          end else if (w_misal) begin
            w_gpr_we_n = 1'b1;
            w_miss     = 1'b1;
          end else begin
            w_bus_addr  = ExOut[WORD_W-1:2];
            w_bus_wdata = ExMemWrData;
            w_dst       = ExDstAddr;
            w_dst_we_n  = ExGprWE_;
            w_bus_req   = 1'b1;
            w_bus_rw    = w_is_load;
            w_cnt       = '0;
            w_gpr_we_n  = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (!BusRdy_) begin
          w_bus_req = 1'b0;
          if (r_bus_rw) begin
            w_gpr_we_n = r_dst_we_n;
            w_gpr_addr = r_dst;
            w_gpr_data = BusRdData;
          end else begin
            w_gpr_we_n = 1'b1;
          end
        end else begin
          w_cnt = w_cnt_inc;
          if (w_timeout) begin
            w_bus_req  = 1'b0;
            w_err      = 1'b1;
            w_gpr_we_n = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign BusReq    = r_bus_req;
  assign BusRw     = r_bus_rw;
  assign BusAddr   = r_bus_addr;
  assign BusWrData = r_bus_wdata;
  assign BusyStall = r_busy;
  assign MissAlign = r_miss;
  assign BusErr    = r_err;
  assign GprWE_    = r_gpr_we_n;
  assign GprWrAddr = r_gpr_addr;
  assign GprWrData = r_gpr_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected register-file writes go into a
// scoreboard queue and a negedge monitor pops one per observed write.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_;
  logic        Stall, Flush, ExEn;
  logic [1:0]  ExMemOp;
  logic [31:0] ExOut, ExMemWrData;
  logic [4:0]  ExDstAddr;
  logic        ExGprWE_;
  logic        BusReq, BusRw;
  logic [29:0] BusAddr;
  logic [31:0] BusWrData;
  logic        BusRdy_;
  logic [31:0] BusRdData;
  logic        BusyStall, MissAlign, BusErr, GprWE_;
  logic [4:0]  GprWrAddr;
  logic [31:0] GprWrData;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;
  wr_t exp_q[$];

  mem_wb_stage #(.WORD_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset_(reset_), .Stall(Stall), .Flush(Flush), .ExEn(ExEn),
    .ExMemOp(ExMemOp), .ExOut(ExOut), .ExMemWrData(ExMemWrData),
    .ExDstAddr(ExDstAddr), .ExGprWE_(ExGprWE_), .BusReq(BusReq), .BusRw(BusRw),
    .BusAddr(BusAddr), .BusWrData(BusWrData), .BusRdy_(BusRdy_),
    .BusRdData(BusRdData), .BusyStall(BusyStall), .MissAlign(MissAlign),
    .BusErr(BusErr), .GprWE_(GprWE_), .GprWrAddr(GprWrAddr), .GprWrData(GprWrData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " BusReq"}, 64'(BusReq), 64'd0);
    chk({tag, " BusRw"}, 64'(BusRw), 64'd1);
    chk({tag, " BusAddr"}, 64'(BusAddr), 64'd0);
    chk({tag, " BusWrData"}, 64'(BusWrData), 64'd0);
    chk({tag, " BusyStall"}, 64'(BusyStall), 64'd0);
    chk({tag, " MissAlign"}, 64'(MissAlign), 64'd0);
    chk({tag, " BusErr"}, 64'(BusErr), 64'd0);
    chk({tag, " GprWE_"}, 64'(GprWE_), 64'd1);
    chk({tag, " GprWrAddr"}, 64'(GprWrAddr), 64'd0);
    chk({tag, " GprWrData"}, 64'(GprWrData), 64'd0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] out,
                       input logic [31:0] wd, input logic [4:0] dst, input logic we_n);
    ExEn = 1'b1; ExMemOp = op; ExOut = out; ExMemWrData = wd;
    ExDstAddr = dst; ExGprWE_ = we_n;
  endtask

  // Monitor: every cycle the write port is enabled must match the queue head.
  always @(negedge clk) begin
    if (mon_en && GprWE_ == 1'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got r%0d=%0h expected no write", GprWrAddr, GprWrData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (GprWrAddr !== e.a || GprWrData !== e.d) begin
          n_errors++;
          $display("FAIL gpr_write: got r%0d=%0h expected r%0d=%0h",
                   GprWrAddr, GprWrData, e.a, e.d);
        end
      end
    end
  end

  initial begin
    reset_ = 1'b1; Stall = 1'b0; Flush = 1'b0; ExEn = 1'b0; ExMemOp = 2'b00;
    ExOut = '0; ExMemWrData = '0; ExDstAddr = '0; ExGprWE_ = 1'b1;
    BusRdy_ = 1'b1; BusRdData = '0;
    step(); step();
    chk_reset_vals("reset");
    reset_ = 1'b0;
    mon_en = 1'b1;

    // ADD-type: one-cycle latency write
    issue(2'b00, 32'h1234, 32'h0, 5'd3, 1'b0);
    exp_q.push_back('{a: 5'd3, d: 32'h1234});
    step();
    chk("add GprWE_", 64'(GprWE_), 64'd0);
    chk("add GprWrData", 64'(GprWrData), 64'h1234);
    ExEn = 1'b0;
    step();
    chk("bubble GprWE_", 64'(GprWE_), 64'd1);

    // reserved opcode behaves as a plain write-back
    issue(2'b11, 32'hCAFE, 32'h0, 5'd12, 1'b0);
    exp_q.push_back('{a: 5'd12, d: 32'hCAFE});
    step();
    ExEn = 1'b0;
    step();

    // Stall holds the bubble; ExGprWE_=1 gives no write either
    Stall = 1'b1;
    issue(2'b00, 32'h77, 32'h0, 5'd2, 1'b0);
    step();
    chk("stall GprWE_", 64'(GprWE_), 64'd1);
    Stall = 1'b0;
    issue(2'b00, 32'h88, 32'h0, 5'd2, 1'b1);
    step();
    chk("we_n=1 GprWE_", 64'(GprWE_), 64'd1);

    // Load 0x100, BusRdy_ low in the third ACCESS cycle
    issue(2'b01, 32'h100, 32'h0, 5'd7, 1'b0);
    step();
    ExEn = 1'b0;
    chk("ld BusReq", 64'(BusReq), 64'd1);
    chk("ld BusRw", 64'(BusRw), 64'd1);
    chk("ld BusAddr", 64'(BusAddr), 64'h40);
    begin
      int busy_cyc = 0;
      for (int i = 0; i < 3; i++) begin
        if (BusyStall) busy_cyc++;
        chk("ld GprWE_ wait", 64'(GprWE_), 64'd1);
        if (i == 2) begin
          BusRdy_ = 1'b0; BusRdData = 32'hDEADBEEF;
          exp_q.push_back('{a: 5'd7, d: 32'hDEADBEEF});
        end
        step();
      end
      chk("ld busy cycles", 64'(busy_cyc), 64'd3);
    end
    BusRdy_ = 1'b1; BusRdData = '0;
    chk("ld done BusyStall", 64'(BusyStall), 64'd0);
    chk("ld done BusReq", 64'(BusReq), 64'd0);
    chk("ld GprWrData", 64'(GprWrData), 64'hDEADBEEF);
    step();
    chk("ld write once", 64'(GprWE_), 64'd1);

    // Store to 0x8, zero-wait bus, GprWE_ must stay high
    issue(2'b10, 32'h8, 32'hA5A5A5A5, 5'd4, 1'b0);
    step();
    ExEn = 1'b0;
    chk("st BusReq", 64'(BusReq), 64'd1);
    chk("st BusRw", 64'(BusRw), 64'd0);
    chk("st BusWrData", 64'(BusWrData), 64'hA5A5A5A5);
    chk("st BusAddr", 64'(BusAddr), 64'h2);
    BusRdy_ = 1'b0;
    step();
    BusRdy_ = 1'b1;
    chk("st BusReq drop", 64'(BusReq), 64'd0);
    chk("st BusyStall", 64'(BusyStall), 64'd0);
    chk("st GprWE_", 64'(GprWE_), 64'd1);

    // Misaligned load
    issue(2'b01, 32'h102, 32'h0, 5'd6, 1'b0);
    step();
    ExEn = 1'b0;
    chk("mis MissAlign", 64'(MissAlign), 64'd1);
    chk("mis BusReq", 64'(BusReq), 64'd0);
    chk("mis BusyStall", 64'(BusyStall), 64'd0);
    step();
    chk("mis pulse end", 64'(MissAlign), 64'd0);

    // Timeout after 4 ACCESS cycles
    issue(2'b01, 32'h200, 32'h0, 5'd9, 1'b0);
    step();
    ExEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to busy", 64'(BusyStall), 64'd1);
      chk("to no err", 64'(BusErr), 64'd0);
      step();
    end
    chk("to BusErr", 64'(BusErr), 64'd1);
    chk("to BusReq", 64'(BusReq), 64'd0);
    chk("to BusyStall", 64'(BusyStall), 64'd0);
    chk("to MissAlign", 64'(MissAlign), 64'd0);
    Flush = 1'b1;
    issue(2'b00, 32'h55, 32'h0, 5'd4, 1'b0);
    step();
    chk("flush GprWE_", 64'(GprWE_), 64'd1);
    chk("flush BusErr end", 64'(BusErr), 64'd0);
    Flush = 1'b0; ExEn = 1'b0;

    // Reset during ACCESS
    issue(2'b01, 32'h300, 32'h0, 5'd5, 1'b0);
    step();
    ExEn = 1'b0;
    chk("rst pre busy", 64'(BusyStall), 64'd1);
    reset_ = 1'b1;
    step();
    chk_reset_vals("rst_access");
    reset_ = 1'b0;
    BusRdy_ = 1'b0; BusRdData = 32'h12345678;
    step();
    chk("rst after GprWE_", 64'(GprWE_), 64'd1);
    chk("rst after BusReq", 64'(BusReq), 64'd0);
    BusRdy_ = 1'b1;
    step();
    step();
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
